// File: rtl/gpio_debug_bridge.sv
// GPIO command/readback bridge: toggle-handshaked frames drive pipeline run/stop/step/reset
// and return coherent multi-frame snapshots of debug channels. Optional macro: GPIO_BRIDGE_SYNC_EN.
module gpio_debug_bridge #(
    parameter int NB_FRAME = 32,
    parameter int NB_CMD   = 4,
    parameter int N_CHAN   = 4,
    parameter int NB_CHAN  = 64
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NB_FRAME-1:0]        i_frame_from_blaze,
    input  logic [N_CHAN*NB_CHAN-1:0]  i_channels,
    output logic [NB_FRAME-1:0]        o_frame_to_blaze,
    output logic                       o_pipe_enable,
    output logic                       o_pipe_reset,
    output logic                       o_busy
);

    localparam int NB_CHUNK = NB_FRAME - 2;
    localparam int NB_ARG   = NB_FRAME - 1 - NB_CMD;
    localparam int N_CHUNKS = (NB_CHAN + NB_CHUNK - 1) / NB_CHUNK;
    localparam int NB_PAD   = N_CHUNKS * NB_CHUNK;

    localparam logic [NB_CMD-1:0] OP_NOP        = NB_CMD'(0);
    localparam logic [NB_CMD-1:0] OP_RUN        = NB_CMD'(1);
    localparam logic [NB_CMD-1:0] OP_STOP       = NB_CMD'(2);
    localparam logic [NB_CMD-1:0] OP_STEP       = NB_CMD'(3);
    localparam logic [NB_CMD-1:0] OP_RESET_PIPE = NB_CMD'(4);
    localparam logic [NB_CMD-1:0] OP_READ       = NB_CMD'(5);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_STEPPING
    } state_t;

    state_t                state_q, state_d;
    logic                  acc_tog_q, acc_tog_d;
    logic [NB_CMD-1:0]     op_q, op_d;
    logic [NB_ARG-1:0]     arg_q, arg_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [NB_CHUNK-1:0]   data_q, data_d;
    logic                  run_q, run_d;
    logic                  step_en_q, step_en_d;
    logic                  pipe_rst_q, pipe_rst_d;
    logic [NB_ARG-1:0]     cnt_q, cnt_d;
    logic [NB_CHAN-1:0]    snap_q, snap_d;

    logic                  req_tog;

`ifdef GPIO_BRIDGE_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_frame_from_blaze[NB_FRAME-1];
            sync2_q <= sync1_q;
        end
    end

    assign req_tog = sync2_q;
`else
    assign req_tog = i_frame_from_blaze[NB_FRAME-1];
`endif

    // Channel and chunk views; the padded vectors make the last chunk zero-extended.
    logic [NB_CHAN-1:0]  chan_arr    [N_CHAN];
    logic [NB_CHUNK-1:0] live_chunks [N_CHUNKS];
    logic [NB_CHUNK-1:0] snap_chunks [N_CHUNKS];
    logic [NB_CHAN-1:0]  live_sel;
    logic [NB_PAD-1:0]   live_pad;
    logic [NB_PAD-1:0]   snap_pad;

    assign live_pad = NB_PAD'(live_sel);
    assign snap_pad = NB_PAD'(snap_q);

    genvar gi;
    generate
        for (gi = 0; gi < N_CHAN; gi++) begin : g_chan
            assign chan_arr[gi] = i_channels[gi*NB_CHAN +: NB_CHAN];
        end
        for (gi = 0; gi < N_CHUNKS; gi++) begin : g_chunk
            assign live_chunks[gi] = live_pad[gi*NB_CHUNK +: NB_CHUNK];
            assign snap_chunks[gi] = snap_pad[gi*NB_CHUNK +: NB_CHUNK];
        end
    endgenerate

    logic [3:0]          c_idx;
    logic [3:0]          k_idx;
    logic                read_ok;
    logic [NB_CHUNK-1:0] snap_chunk;

    assign c_idx   = arg_q[3:0];
    assign k_idx   = arg_q[7:4];
    assign read_ok = (32'(k_idx) < N_CHAN) && (32'(c_idx) < N_CHUNKS);

    always_comb begin
        live_sel   = '0;
        snap_chunk = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (k_idx == 4'(i)) live_sel = chan_arr[i];
        end
        for (int i = 0; i < N_CHUNKS; i++) begin
            if (c_idx == 4'(i)) snap_chunk = snap_chunks[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_tog_d  = acc_tog_q;
        op_d       = op_q;
        arg_d      = arg_q;
        ack_d      = ack_q;
        err_d      = err_q;
        data_d     = data_q;
        run_d      = run_q;
        step_en_d  = step_en_q;
        pipe_rst_d = 1'b0;
        cnt_d      = cnt_q;
        snap_d     = snap_q;

        case (state_q)
            ST_IDLE: begin
                if (req_tog != acc_tog_q) begin
                    state_d   = ST_DECODE;
                    acc_tog_d = req_tog;
                    op_d      = i_frame_from_blaze[NB_FRAME-2 -: NB_CMD];
                    arg_d     = i_frame_from_blaze[NB_ARG-1:0];
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                ack_d   = ~ack_q;
                err_d   = 1'b0;
                data_d  = '0;
                case (op_q)
                    OP_NOP:  ;
                    OP_RUN:  run_d = 1'b1;
                    OP_STOP: run_d = 1'b0;
                    OP_STEP: begin
                        run_d = 1'b0;
                        // Response frame stays frozen until the step count expires.
                        if (arg_q != '0) begin
                            state_d   = ST_STEPPING;
                            ack_d     = ack_q;
                            err_d     = err_q;
                            data_d    = data_q;
                            step_en_d = 1'b1;
                            cnt_d     = arg_q;
                        end
                    end
                    OP_RESET_PIPE: begin
                        pipe_rst_d = 1'b1;
                        run_d      = 1'b0;
                    end
                    OP_READ: begin
                        if (!read_ok) begin
                            err_d = 1'b1;
                        end else if (c_idx == 4'd0) begin
                            snap_d = live_sel;
                            data_d = live_chunks[0];
                        end else begin
                            data_d = snap_chunk;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
            ST_STEPPING: begin
                if (cnt_q == NB_ARG'(1)) begin
                    state_d   = ST_IDLE;
                    step_en_d = 1'b0;
                    ack_d     = ~ack_q;
                    err_d     = 1'b0;
                    data_d    = '0;
                end else begin
                    cnt_d = cnt_q - NB_ARG'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            acc_tog_q  <= 1'b0;
            op_q       <= '0;
            arg_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            run_q      <= 1'b0;
            step_en_q  <= 1'b0;
            pipe_rst_q <= 1'b0;
            cnt_q      <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_tog_q  <= acc_tog_d;
            op_q       <= op_d;
            arg_q      <= arg_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            data_q     <= data_d;
            run_q      <= run_d;
            step_en_q  <= step_en_d;
            pipe_rst_q <= pipe_rst_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
        end
    end

    assign o_frame_to_blaze = {ack_q, err_q, data_q};
    assign o_pipe_enable    = run_q | step_en_q;
    assign o_pipe_reset     = pipe_rst_q;
    assign o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_debug_bridge.sv
// Directed self-checking bench for gpio_debug_bridge; latencies follow GPIO_BRIDGE_SYNC_EN.
module tb_gpio_debug_bridge;

    localparam int NB_FRAME = 32;
    localparam int NB_CMD   = 4;
    localparam int N_CHAN   = 4;
    localparam int NB_CHAN  = 64;
`ifdef GPIO_BRIDGE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NB_FRAME-1:0]       frame_in = '0;
    logic [N_CHAN*NB_CHAN-1:0] chans = '0;
    logic [NB_FRAME-1:0]       frame_out;
    logic                      pipe_en;
    logic                      pipe_rst;
    logic                      busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic host_tog = 1'b0;

    gpio_debug_bridge #(
        .NB_FRAME (NB_FRAME),
        .NB_CMD   (NB_CMD),
        .N_CHAN   (N_CHAN),
        .NB_CHAN  (NB_CHAN)
    ) dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_frame_from_blaze (frame_in),
        .i_channels         (chans),
        .o_frame_to_blaze   (frame_out),
        .o_pipe_enable      (pipe_en),
        .o_pipe_reset       (pipe_rst),
        .o_busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [26:0] arg);
        @(negedge clk);
        host_tog = ~host_tog;
        frame_in = {host_tog, op, arg};
        $display("cmd op=%0d arg=%07h tog=%0b t=%0t", op, arg, host_tog, $time);
    endtask

    task automatic wait_decode;
        repeat (LAT + 1) tick();
    endtask

    task automatic test_reset;
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({frame_out, pipe_en, pipe_rst, busy} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_async: got %h/%b%b%b want 0/000", frame_out, pipe_en, pipe_rst, busy);
        end
        tick();
        n_cmp++;
        if ({frame_out, pipe_en, pipe_rst, busy} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_held: got %h/%b%b%b want 0/000", frame_out, pipe_en, pipe_rst, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nop;
        drive_cmd(4'd0, 27'd0);
        wait_decode();
        n_cmp++;
        if ({busy, frame_out[31]} !== 2'b10) begin
            n_bad++;
            $display("FAIL nop_pre_ack: busy/ack got %b%b want 10", busy, frame_out[31]);
        end
        tick();
        n_cmp++;
        if (frame_out !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL nop_ack: got %h want 80000000", frame_out);
        end
        n_cmp++;
        if ({busy, pipe_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL nop_idle: busy/en got %b%b want 00", busy, pipe_en);
        end
    endtask

    task automatic test_run_stop;
        drive_cmd(4'd1, 27'd0);
        wait_decode();
        n_cmp++;
        if (pipe_en !== 1'b0) begin
            n_bad++;
            $display("FAIL run_early: en got %b want 0", pipe_en);
        end
        tick();
        n_cmp++;
        if ({frame_out, pipe_en} !== {32'h0000_0000, 1'b1}) begin
            n_bad++;
            $display("FAIL run_ack: frame/en got %h/%b want 00000000/1", frame_out, pipe_en);
        end
        repeat (3) tick();
        drive_cmd(4'd2, 27'd0);
        wait_decode();
        n_cmp++;
        if (pipe_en !== 1'b1) begin
            n_bad++;
            $display("FAIL run_hold: en got %b want 1", pipe_en);
        end
        tick();
        n_cmp++;
        if ({frame_out, pipe_en} !== {32'h8000_0000, 1'b0}) begin
            n_bad++;
            $display("FAIL stop_ack: frame/en got %h/%b want 80000000/0", frame_out, pipe_en);
        end
    endtask

    task automatic test_step;
        int   hi;
        int   ack_at;
        logic busy_dropped;
        hi = 0;
        ack_at = 0;
        busy_dropped = 1'b0;
        drive_cmd(4'd3, 27'd5);
        wait_decode();
        n_cmp++;
        if ({busy, pipe_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL step_pre: busy/en got %b%b want 10", busy, pipe_en);
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (frame_out[31] === host_tog) begin
                ack_at = i;
                break;
            end
            if (busy !== 1'b1) busy_dropped = 1'b1;
            if (pipe_en === 1'b1) hi++;
        end
        n_cmp++;
        if (hi != 5 || ack_at != 6) begin
            n_bad++;
            $display("FAIL step5_len: enable cycles %0d ack tick %0d want 5 and 6", hi, ack_at);
        end
        n_cmp++;
        if ({busy_dropped, busy, pipe_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL step5_end: dropped/busy/en got %b%b%b want 000", busy_dropped, busy, pipe_en);
        end
        drive_cmd(4'd1, 27'd0);
        repeat (LAT + 2) tick();
        drive_cmd(4'd3, 27'd0);
        wait_decode();
        n_cmp++;
        if (pipe_en !== 1'b1) begin
            n_bad++;
            $display("FAIL step0_pre: en got %b want 1", pipe_en);
        end
        tick();
        n_cmp++;
        if ({frame_out, pipe_en, busy} !== {host_tog, 31'h0, 2'b00}) begin
            n_bad++;
            $display("FAIL step0_ack: frame/en/busy got %h/%b%b want %h/00", frame_out, pipe_en, busy, {host_tog, 31'h0});
        end
        hi = 0;
        repeat (4) begin
            tick();
            if (pipe_en === 1'b1) hi++;
        end
        n_cmp++;
        if (hi != 0) begin
            n_bad++;
            $display("FAIL step0_quiet: enable cycles %0d want 0", hi);
        end
    endtask

    task automatic test_read;
        logic [3:0]  ops  [10] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd7, 4'd15, 4'd5};
        logic [26:0] args [10] = '{27'h20, 27'h21, 27'h22, 27'h20, 27'h22, 27'h23, 27'h40, 27'h0, 27'h20, 27'h30};
        logic [30:0] exps [10] = '{{1'b0, 30'h09AB_CDEF}, {1'b0, 30'h048D_159E}, {1'b0, 30'h0000_0000},
                                   {1'b0, 30'h3FFF_FFFF}, {1'b0, 30'h0000_000F}, {1'b1, 30'h0},
                                   {1'b1, 30'h0}, {1'b1, 30'h0}, {1'b1, 30'h0}, {1'b0, 30'h3654_3210}};
        chans[2*NB_CHAN +: NB_CHAN] = 64'h0123_4567_89AB_CDEF;
        chans[3*NB_CHAN +: NB_CHAN] = 64'hFEDC_BA98_7654_3210;
        for (int i = 0; i < 10; i++) begin
            drive_cmd(ops[i], args[i]);
            repeat (LAT + 2) tick();
            n_cmp++;
            if (frame_out !== {host_tog, exps[i]}) begin
                n_bad++;
                $display("FAIL read_%0d: op %0d arg %h got %h want %h", i, ops[i], args[i], frame_out, {host_tog, exps[i]});
            end
            if (i == 0) chans[2*NB_CHAN +: NB_CHAN] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
    endtask

    task automatic test_queued;
        int   hi;
        int   ack_at;
        int   run_at;
        logic step_tog;
        hi = 0;
        ack_at = 0;
        run_at = 0;
        drive_cmd(4'd3, 27'd10);
        step_tog = host_tog;
        wait_decode();
        for (int i = 1; i <= 40; i++) begin
            if (i == 3) drive_cmd(4'd1, 27'd0);
            tick();
            if (frame_out[31] === step_tog) begin
                ack_at = i;
                break;
            end
            if (pipe_en === 1'b1) hi++;
        end
        n_cmp++;
        if (hi != 10 || ack_at != 11) begin
            n_bad++;
            $display("FAIL queued_step: enable cycles %0d ack tick %0d want 10 and 11", hi, ack_at);
        end
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (frame_out[31] === host_tog) begin
                run_at = j;
                break;
            end
        end
        n_cmp++;
        if (run_at != 2 || pipe_en !== 1'b1) begin
            n_bad++;
            $display("FAIL queued_run: ack tick %0d en %b want 2 and 1", run_at, pipe_en);
        end
    endtask

    task automatic test_reset_pipe;
        int width;
        width = 0;
        drive_cmd(4'd4, 27'd0);
        wait_decode();
        n_cmp++;
        if ({pipe_rst, pipe_en} !== 2'b01) begin
            n_bad++;
            $display("FAIL rstpipe_pre: rst/en got %b%b want 01", pipe_rst, pipe_en);
        end
        tick();
        n_cmp++;
        if ({frame_out, pipe_rst, pipe_en} !== {host_tog, 31'h0, 2'b10}) begin
            n_bad++;
            $display("FAIL rstpipe_ack: frame/rst/en got %h/%b%b want %h/10", frame_out, pipe_rst, pipe_en, {host_tog, 31'h0});
        end
        repeat (4) begin
            tick();
            if (pipe_rst === 1'b1) width++;
        end
        n_cmp++;
        if (width != 0 || pipe_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rstpipe_pulse: extra cycles %0d en %b want 0 and 0", width, pipe_en);
        end
    endtask

    task automatic test_async_reset;
        drive_cmd(4'd3, 27'd10);
        wait_decode();
        repeat (3) tick();
        n_cmp++;
        if ({busy, pipe_en} !== 2'b11) begin
            n_bad++;
            $display("FAIL midstep_pre: busy/en got %b%b want 11", busy, pipe_en);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({frame_out, pipe_en, pipe_rst, busy} !== 35'h0) begin
            n_bad++;
            $display("FAIL midstep_reset: got %h/%b%b%b want 0/000", frame_out, pipe_en, pipe_rst, busy);
        end
        host_tog = 1'b0;
        frame_in = '0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        drive_cmd(4'd0, 27'd0);
        repeat (LAT + 2) tick();
        n_cmp++;
        if (frame_out !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL post_reset_nop: got %h want 80000000", frame_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nop();
        test_run_stop();
        test_step();
        test_read();
        test_queued();
        test_reset_pipe();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_debug_bridge.md
# gpio_debug_bridge

Command/readback bridge between the MicroBlaze GPIO pair (32-bit frame in, 32-bit frame out) and the MIPS pipeline. It decodes toggle-handshaked command frames into pipeline run/stop/step/reset control. It also returns any of `N_CHAN` wide debug channels as coherent multi-frame snapshots. It sits between the soft-core GPIO and `pipeline` in the top level, with `o_busy` driven to a LED.

## Interface
- `NB_FRAME`, 32: GPIO frame width, both directions.
- `NB_CMD`, 4: opcode field width.
- `N_CHAN`, 4: number of debug channels, at most 16.
- `NB_CHAN`, 64: width of each channel. `ceil(NB_CHAN/(NB_FRAME-2))` must be at most 16.
- `i_clock` in 1: sole clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_frame_from_blaze` in `NB_FRAME`: command frame.
  - `[NB_FRAME-1]` is the request toggle.
  - `[NB_FRAME-2 -: NB_CMD]` is the opcode.
  - The remaining low bits are ARG.
- `i_channels` in `N_CHAN*NB_CHAN`: channel k is at `[k*NB_CHAN +: NB_CHAN]`.
- `o_frame_to_blaze` out `NB_FRAME`: response frame.
  - `[NB_FRAME-1]` is the ack toggle.
  - `[NB_FRAME-2]` is the error flag.
  - `[NB_FRAME-3:0]` is the data chunk. Chunk width `NB_CHUNK = NB_FRAME-2`.
- `o_pipe_enable` out 1: pipeline valid/enable.
- `o_pipe_reset` out 1: pipeline reset pulse.
- `o_busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Handshake: the host changes the input toggle only when the toggle equals the current ack toggle, and holds opcode/ARG stable until ack toggles. A command is detected when the (synchronised) toggle differs from the last accepted toggle.
- FSM states are IDLE, DECODE, STEPPING.
- IDLE -> DECODE on detection. The opcode and ARG are latched and the accepted toggle is updated.
- DECODE -> IDLE after executing any command except STEP.
- DECODE -> STEPPING for STEP with ARG != 0.
- STEPPING -> IDLE when the step counter expires.
- Opcodes:
  - 0 NOP: ack only.
  - 1 RUN: set the run flag, so `o_pipe_enable` = 1.
  - 2 STOP: clear the run flag.
  - 3 STEP: `o_pipe_enable` is high for exactly ARG cycles, then 0. The run flag is cleared. ARG = 0 acks immediately with no enable cycle.
  - 4 RESET_PIPE: `o_pipe_reset` is high for exactly 1 cycle, and the run flag is cleared.
  - 5 READ:
    - ARG[3:0] is the chunk index c; ARG[7:4] is the channel index k.
    - c = 0 copies channel k into the snapshot register and returns chunk 0 of the live value.
    - c > 0 returns chunk c of the snapshot, i.e. snapshot bits `[c*NB_CHUNK +: NB_CHUNK]`.
    - The last chunk is zero-extended.
  - Anything else is an error.
- Error response: k >= `N_CHAN`, or c >= chunk count, or an undefined opcode gives error = 1 and data = 0. For non-READ commands the data field is 0.
- A toggle change while in DECODE or STEPPING is not lost. It is detected on return to IDLE.
- Reset value of every output is 0: frame, enable, reset pulse, busy. The accepted toggle, ack toggle, run flag, snapshot and counter also reset to 0, so the host starts with toggle = 0.
- Asserting `i_reset` mid-STEP drops `o_pipe_enable` immediately and the state goes to IDLE. No ack is issued.

## Timing
- Let E0 be the first rising edge at which the new toggle is present.
- With sync:
  - sync1 at E0, sync2 at E1, DECODE entered at E2.
  - The response frame (data, error, ack toggle) updates together at E3.
  - RUN/STOP take effect on `o_pipe_enable` at E3.
  - `o_pipe_reset` is high from E3 to E4.
- STEP N:
  - `o_pipe_enable` is high from E3 through E3+N.
  - The ack toggles at E3+N, the same edge at which enable falls.
- `o_busy` is high from E2 until the edge at which the ack toggles.
- Step counter width is `NB_FRAME-1-NB_CMD` bits. The maximum ARG is accepted with no wrap.

## Configuration
- `GPIO_BRIDGE_SYNC_EN` defined: a two-flop synchroniser is placed on the request toggle, giving the latencies above. This is for a GPIO clock asynchronous to `i_clock`.
- Undefined: the raw toggle feeds the edge comparator directly. DECODE is entered at E0, the ack at E1, and every latency above is reduced by 2 cycles.

## Test plan
- Reset: assert `i_reset` mid-frame -> all outputs 0 asynchronously. Then NOP toggle 0->1 -> ack bit 1 at E3 with error = 0 and data = 0.
- RUN, then STOP -> `o_pipe_enable` 1 from the first ack edge and 0 from the second. Each ack alternates the toggle.
- STEP ARG = 5 -> enable high exactly 5 cycles, ack on the falling edge, `o_busy` high throughout. STEP ARG = 0 -> no enable pulse, ack at E3.
- READ channel 2 = 64'h0123_4567_89AB_CDEF:
  - chunk 0 returns 30'h09AB_CDEF.
  - Change channel 2, then chunks 1 and 2 return the bits of the old value: 30'h048D_159E and 30'h0000_0000.
  - READ k = 4 -> error = 1, data = 0.
- Toggle changed during STEP ARG = 10 -> that command executes after the STEP ack, never dropped. RESET_PIPE -> one-cycle `o_pipe_reset` and the run flag cleared.
- Build without `GPIO_BRIDGE_SYNC_EN` -> NOP ack at E1.
